reg_file_sb: RTL and testbench

REG_FILE_SB -- requirements
Module: reg_file_sb

---
 rtl/reg_file_pkg.sv | 11 +
 rtl/rf_scoreboard.sv | 66 ++++++
 rtl/reg_file_sb.sv | 95 +++++++++
 tb/tb_reg_file_sb.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared definitions for the scoreboarded register file.
//   DEFAULT_DATA_W / DEFAULT_ADDR_W : default register width and address width
//   reg_idx_t                       : register index at the default address width
package reg_file_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_ADDR_W = 5;

  typedef logic [DEFAULT_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by a reservation and
// cleared by the writeback that retires it. The pending count is registered.
//   i_clk, i_rst_n          : clock, asynchronous active-low reset
//   i_rsv_v, i_rsv_addr     : reserve a destination register
//   i_clr_v, i_clr_addr     : writeback retiring a register
//   i_flush                 : clear every pending bit
//   o_pend                  : registered pending bits, one per register
//   o_pend_cnt              : registered popcount of o_pend
module rf_scoreboard
  import reg_file_pkg::*;
#(
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int ZERO_REG = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_rsv_v,
  input  logic [ADDR_W-1:0]       i_rsv_addr,
  input  logic                    i_clr_v,
  input  logic [ADDR_W-1:0]       i_clr_addr,
  input  logic                    i_flush,
  output logic [(2**ADDR_W)-1:0]  o_pend,
  output logic [ADDR_W:0]         o_pend_cnt
);

  localparam int DEPTH   = 2**ADDR_W;
  localparam bit ZERO_EN = (ZERO_REG != 0);

  logic [DEPTH-1:0] pend_q, pend_d;
  logic [ADDR_W:0]  cnt_q, cnt_d;

  // NOTE: every variable gets a default at the top of always_comb so no path
  // leaves it unassigned; that is what keeps synthesis from inferring a latch.
  always_comb begin
    pend_d = pend_q;
    if (i_flush) begin
      pend_d = '0;
    end else begin
      // Clear first, then set: a same-cycle reserve of the written register
      // is a newer instruction and must stay pending.
      if (i_clr_v) pend_d[i_clr_addr] = 1'b0;
      if (i_rsv_v && !(ZERO_EN && i_rsv_addr == '0)) pend_d[i_rsv_addr] = 1'b1;
    end

    cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      cnt_d = cnt_d + {{ADDR_W{1'b0}}, pend_d[i]};
    end
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample
  // their inputs at the same edge, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

  assign o_pend     = pend_q;
  assign o_pend_cnt = cnt_q;

endmodule

// File: rtl/reg_file_sb.sv
// Multi-ported register file with write-through bypass and a pending-write
// scoreboard.
//   i_clk, i_rst_n                  : clock, asynchronous active-low reset
//   i_rd_addr  [NUM_RD*ADDR_W]      : packed read addresses, port k = slice k
//   o_rd_data  [NUM_RD*DATA_W]      : packed combinational read data
//   o_rd_busy  [NUM_RD]             : addressed register still awaits a write
//   i_we, i_wr_addr, i_wr_data      : writeback request
//   i_rsv_v, i_rsv_addr             : reserve a destination register
//   i_flush                         : drop all reservations
//   o_pend_cnt [ADDR_W+1]           : number of registers pending
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int DATA_W   = DEFAULT_DATA_W,
  parameter int ADDR_W   = DEFAULT_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] i_rd_addr,
  output logic [NUM_RD*DATA_W-1:0] o_rd_data,
  output logic [NUM_RD-1:0]        o_rd_busy,
  input  logic                     i_we,
  input  logic [ADDR_W-1:0]        i_wr_addr,
  input  logic [DATA_W-1:0]        i_wr_data,
  input  logic                     i_rsv_v,
  input  logic [ADDR_W-1:0]        i_rsv_addr,
  input  logic                     i_flush,
  output logic [ADDR_W:0]          o_pend_cnt
);

  localparam int DEPTH   = 2**ADDR_W;
  localparam bit ZERO_EN = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic              wr_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              bypass;

  // A write to the hardwired zero register is dropped everywhere: array,
  // bypass and scoreboard clear.
  assign wr_en = i_we && !(ZERO_EN && i_wr_addr == '0);

  // NOTE: the array is reset entry by entry because its contents must read
  // as zero out of reset; this rules out mapping it onto a RAM macro.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[i_wr_addr] <= i_wr_data;
    end
  end

  // Read ports. The array is already zero during reset, but the bypass path
  // is not, so reset also gates the outputs directly.
  always_comb begin
    o_rd_data = '0;
    o_rd_busy = '0;
    rd_addr   = '0;
    bypass    = 1'b0;
    for (int k = 0; k < NUM_RD; k++) begin
      rd_addr = i_rd_addr[k*ADDR_W +: ADDR_W];
      bypass  = wr_en && (i_wr_addr == rd_addr);
      if (i_rst_n) begin
        if (ZERO_EN && rd_addr == '0) begin
          o_rd_data[k*DATA_W +: DATA_W] = '0;
        end else if (bypass) begin
          o_rd_data[k*DATA_W +: DATA_W] = i_wr_data;
        end else begin
          o_rd_data[k*DATA_W +: DATA_W] = mem_q[rd_addr];
        end
        // The value being bypassed is the one the reader was waiting for.
        o_rd_busy[k] = pend[rd_addr] && !bypass;
      end
    end
  end

  rf_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_rsv_v    (i_rsv_v),
    .i_rsv_addr (i_rsv_addr),
    .i_clr_v    (wr_en),
    .i_clr_addr (i_wr_addr),
    .i_flush    (i_flush),
    .o_pend     (pend),
    .o_pend_cnt (o_pend_cnt)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
module tb_reg_file_sb;
  import reg_file_pkg::*;

  localparam int DW    = DEFAULT_DATA_W;
  localparam int AW    = DEFAULT_ADDR_W;
  localparam int NR    = 2;
  localparam int DEPTH = 2**AW;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]    rd_busy;
  logic             we;
  logic [AW-1:0]    wr_addr;
  logic [DW-1:0]    wr_data;
  logic             rsv_v;
  logic [AW-1:0]    rsv_addr;
  logic             flush;
  logic [AW:0]      pend_cnt;

  always #5 clk = ~clk;

  reg_file_sb #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .NUM_RD   (NR),
    .ZERO_REG (1)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_rd_addr  (rd_addr),
    .o_rd_data  (rd_data),
    .o_rd_busy  (rd_busy),
    .i_we       (we),
    .i_wr_addr  (wr_addr),
    .i_wr_data  (wr_data),
    .i_rsv_v    (rsv_v),
    .i_rsv_addr (rsv_addr),
    .i_flush    (flush),
    .o_pend_cnt (pend_cnt)
  );

  // Reference model: architectural register contents and the set of
  // registers with an outstanding reservation.
  logic [DW-1:0] m_reg [DEPTH];
  bit            m_pend [DEPTH];

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_reg[i]  = '0;
      m_pend[i] = 1'b0;
    end
  endtask

  function automatic int model_count();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(m_pend[i]);
    return n;
  endfunction

  task automatic drive(input bit w, input int wa, input logic [DW-1:0] wd,
                       input bit r, input int ra, input bit f,
                       input int a0, input int a1);
    we       = w;
    wr_addr  = AW'(wa);
    wr_data  = wd;
    rsv_v    = r;
    rsv_addr = AW'(ra);
    flush    = f;
    rd_addr  = {AW'(a1), AW'(a0)};
  endtask

  // Compare every output against what the register-file rules predict for
  // the current model state and the inputs now applied.
  task automatic check_outputs(input string tag);
    int            a;
    logic [DW-1:0] exp_d;
    bit            exp_b;
    for (int k = 0; k < NR; k++) begin
      a = int'(rd_addr[k*AW +: AW]);
      if (a == 0)                       exp_d = '0;
      else if (we && int'(wr_addr) == a) exp_d = wr_data;
      else                              exp_d = m_reg[a];
      exp_b = m_pend[a] && !(we && a != 0 && int'(wr_addr) == a);
      chk($sformatf("%s.data%0d", tag, k), rd_data[k*DW +: DW], exp_d);
      chk($sformatf("%s.busy%0d", tag, k), {{(DW-1){1'b0}}, rd_busy[k]}, {{(DW-1){1'b0}}, exp_b});
    end
    chk($sformatf("%s.cnt", tag), {{(DW-AW-1){1'b0}}, pend_cnt}, DW'(model_count()));
  endtask

  task automatic model_edge();
    int wa = int'(wr_addr);
    int ra = int'(rsv_addr);
    if (we && wa != 0) m_reg[wa] = wr_data;
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) m_pend[i] = 1'b0;
    end else begin
      if (we) m_pend[wa] = 1'b0;
      if (rsv_v && ra != 0) m_pend[ra] = 1'b1;
    end
  endtask

  // One clock: check the settled outputs mid-cycle, then advance the model
  // with the DUT at the rising edge.
  task automatic cycle(input string tag);
    @(negedge clk);
    check_outputs(tag);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    // Even with a matching write presented, reset forces every read to 0.
    drive(1, 3, 32'h1234_5678, 1, 3, 0, 3, 3);
    #2;
    chk("rst.data0", rd_data[DW-1:0], '0);
    chk("rst.data1", rd_data[2*DW-1:DW], '0);
    chk("rst.cnt", {{(DW-AW-1){1'b0}}, pend_cnt}, '0);
    @(posedge clk);
    #1;
    drive(0, 0, '0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // All addresses read zero after reset.
    for (int a = 0; a < DEPTH; a++) begin
      drive(0, 0, '0, 0, 0, 0, a, DEPTH - 1 - a);
      cycle("scan");
    end

    // Same-cycle bypass, then the stored value.
    drive(1, 5, 32'hDEAD_BEEF, 0, 0, 0, 5, 6);
    cycle("byp5");
    drive(0, 0, '0, 0, 0, 0, 5, 5);
    cycle("rd5");

    // Register 0 is hardwired.
    drive(1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 5);
    cycle("wr0");
    drive(0, 0, '0, 1, 0, 0, 0, 0);
    cycle("rsv0");
    drive(0, 0, '0, 0, 0, 0, 0, 0);
    cycle("post0");
    chk("zero.cnt", {{(DW-AW-1){1'b0}}, pend_cnt}, '0);

    // Reserve / reserve-and-write / retire register 7.
    drive(0, 0, '0, 1, 7, 0, 7, 0);
    cycle("rsv7");
    drive(1, 7, 32'h0000_0777, 1, 7, 0, 0, 0);
    cycle("rsvwr7");
    drive(0, 0, '0, 0, 0, 0, 7, 7);
    cycle("busy7");
    drive(0, 0, '0, 1, 7, 0, 7, 0);
    cycle("rsv7b");
    drive(1, 7, 32'h0000_0778, 0, 0, 0, 7, 1);
    cycle("wr7");
    drive(0, 0, '0, 0, 0, 0, 7, 7);
    cycle("idle7");

    // Flush beats a same-cycle reserve.
    for (int r = 1; r <= 3; r++) begin
      drive(0, 0, '0, 1, r, 0, r, 0);
      cycle("rsv123");
    end
    drive(1, 2, 32'hCAFE_0002, 1, 4, 1, 1, 3);
    cycle("flush");
    for (int r = 1; r <= 4; r++) begin
      drive(0, 0, '0, 0, 0, 0, r, r);
      cycle("postflush");
    end

    // Randomized traffic over a narrow address range to provoke collisions.
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom,
            $urandom_range(0, 1) == 1, $urandom_range(0, 7),
            $urandom_range(0, 19) == 0,
            $urandom_range(0, 7), $urandom_range(0, DEPTH - 1));
      cycle("rand");
    end

    // Asynchronous reset in the middle of a write and reservation to reg 9.
    drive(0, 0, '0, 1, 9, 0, 9, 9);
    cycle("rsv9");
    drive(1, 9, 32'h9999_9999, 1, 10, 0, 9, 10);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("arst.data0", rd_data[DW-1:0], '0);
    chk("arst.cnt", {{(DW-AW-1){1'b0}}, pend_cnt}, '0);
    @(posedge clk);
    #1;
    drive(0, 0, '0, 0, 0, 0, 9, 10);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    cycle("post_arst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
